// File: rtl/offset_adder_arbiter_if.sv
// rtl/offset_adder_arbiter_if.sv - requester and result signal bundle for the shared offset adder
// Groups both requester request/operand/grant signals and the result handshake.
interface offset_adder_arbiter_if #(
    parameter int DW   = 16,
    parameter int IMMW = 8
);
    logic            br_req;
    logic [DW-1:0]   br_base;
    logic [IMMW-1:0] br_imm;
    logic            br_gnt;
    logic            lsu_req;
    logic [DW-1:0]   lsu_base;
    logic [IMMW-1:0] lsu_imm;
    logic            lsu_gnt;
    logic            res_valid;
    logic            res_ready;
    logic [DW-1:0]   res_data;
    logic            res_owner;
    logic            res_ovf;

    modport master (
        output br_req, br_base, br_imm, lsu_req, lsu_base, lsu_imm, res_ready,
        input  br_gnt, lsu_gnt, res_valid, res_data, res_owner, res_ovf
    );

    modport slave (
        input  br_req, br_base, br_imm, lsu_req, lsu_base, lsu_imm, res_ready,
        output br_gnt, lsu_gnt, res_valid, res_data, res_owner, res_ovf
    );
endinterface

// File: rtl/offset_adder_arbiter.sv
// rtl/offset_adder_arbiter.sv - shared base + sign-extended immediate adder for branch and LSU
// OFFSET_ARB_RR_EN selects round-robin arbitration; otherwise branch has fixed priority.
module offset_adder_arbiter #(
    parameter int DW   = 16,
    parameter int IMMW = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    offset_adder_arbiter_if.slave             bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e   state_q, state_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_owner_q, res_owner_d;
    logic          res_ovf_q, res_ovf_d;

    logic            can_grant;
    logic            pick_lsu;
    logic            br_gnt, lsu_gnt;
    logic [DW-1:0]   sel_base;
    logic [IMMW-1:0] sel_imm;
    logic [DW-1:0]   ext_imm;
    logic [DW-1:0]   sum;
    logic            ovf;

`ifdef OFFSET_ARB_RR_EN
    logic last_owner_q, last_owner_d;
`endif

    always_comb begin
        // Reset gates the grants so no requester sees a capture while the slot is cleared.
        can_grant = rst_n && ((state_q == EMPTY) || bus.res_ready);
`ifdef OFFSET_ARB_RR_EN
        pick_lsu  = (bus.br_req && bus.lsu_req) ? !last_owner_q : bus.lsu_req;
`else
        pick_lsu  = bus.lsu_req && !bus.br_req;
`endif
        br_gnt    = can_grant && bus.br_req && !pick_lsu;
        lsu_gnt   = can_grant && pick_lsu;

        sel_base  = pick_lsu ? bus.lsu_base : bus.br_base;
        sel_imm   = pick_lsu ? bus.lsu_imm  : bus.br_imm;
        ext_imm   = {{(DW - IMMW + 1){sel_imm[IMMW-1]}}, sel_imm[IMMW-2:0]};
        sum       = sel_base + ext_imm;
        ovf       = (sel_base[DW-1] == ext_imm[DW-1]) && (sum[DW-1] != sel_base[DW-1]);
    end

    always_comb begin
        state_d     = state_q;
        res_data_d  = res_data_q;
        res_owner_d = res_owner_q;
        res_ovf_d   = res_ovf_q;
`ifdef OFFSET_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        if (br_gnt || lsu_gnt) begin
            state_d     = FULL;
            res_data_d  = sum;
            res_owner_d = lsu_gnt;
            res_ovf_d   = ovf;
`ifdef OFFSET_ARB_RR_EN
            last_owner_d = lsu_gnt;
`endif
        end else if ((state_q == FULL) && bus.res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            res_data_q  <= '0;
            res_owner_q <= 1'b0;
            res_ovf_q   <= 1'b0;
`ifdef OFFSET_ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            res_data_q  <= res_data_d;
            res_owner_q <= res_owner_d;
            res_ovf_q   <= res_ovf_d;
`ifdef OFFSET_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign bus.br_gnt    = br_gnt;
    assign bus.lsu_gnt   = lsu_gnt;
    assign bus.res_valid = (state_q == FULL);
    assign bus.res_data  = res_data_q;
    assign bus.res_owner = res_owner_q;
    assign bus.res_ovf   = res_ovf_q;
endmodule
